// File: rtl/cbrt_pkg.sv
// Shared types and default widths for the cube-root operand dispatcher.
package cbrt_pkg;

  localparam int unsigned DW_DEF    = 8;
  localparam int unsigned RW_DEF    = 4;
  localparam int unsigned TMO_DEF   = 4;
  localparam int unsigned DEPTH_DEF = 4;
  localparam int unsigned TAG_W_DEF = 2;
  localparam int unsigned DONE_W    = 16;

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_WAIT_HI,
    S_WAIT_LO
  } state_t;

endpackage

// File: rtl/cbrt_dispatch_if.sv
// Operand input, cube-root unit link, result output and status of the dispatcher.
interface cbrt_dispatch_if
  import cbrt_pkg::*;
#(
  parameter int unsigned DEPTH = DEPTH_DEF,
  parameter int unsigned TAG_W = TAG_W_DEF,
  parameter int unsigned DW    = DW_DEF,
  parameter int unsigned RW    = RW_DEF
);
  localparam int unsigned LW = $clog2(DEPTH) + 1;

  logic [DW-1:0]     in_data_i;
  logic              in_valid_i;
  logic              in_ready_o;
  logic [DW-1:0]     root_a_o;
  logic              root_start_o;
  logic              root_busy_i;
  logic [RW-1:0]     root_y_i;
  logic [RW-1:0]     out_data_o;
  logic [TAG_W-1:0]  out_tag_o;
  logic              out_valid_o;
  logic              out_ready_i;
  logic [LW-1:0]     level_o;
  logic [DONE_W-1:0] done_cnt_o;
  logic              err_o;

  // Dispatcher side.
  modport master (
    input  in_data_i, in_valid_i, root_busy_i, root_y_i, out_ready_i,
    output in_ready_o, root_a_o, root_start_o, out_data_o, out_tag_o,
           out_valid_o, level_o, done_cnt_o, err_o
  );

  // Producer, cube-root unit and consumer side.
  modport slave (
    output in_data_i, in_valid_i, root_busy_i, root_y_i, out_ready_i,
    input  in_ready_o, root_a_o, root_start_o, out_data_o, out_tag_o,
           out_valid_o, level_o, done_cnt_o, err_o
  );

endinterface

// File: rtl/cbrt_op_fifo.sv
// Operand FIFO: registered storage, no fall-through, occupancy counter.
module cbrt_op_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned DW    = 8,
  localparam int unsigned AW   = $clog2(DEPTH),
  localparam int unsigned LW   = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata_c,
  output logic [LW-1:0] level,
  output logic          full_c,
  output logic          empty_c
);
  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full_c  = (level == LW'(DEPTH));
  assign empty_c = (level == '0);
  assign do_push = push && !full_c;
  assign do_pop  = pop && !empty_c;
  assign rdata_c = mem[rd_ptr];

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= AW'(wr_ptr + 1'b1);
      if (do_pop)  rd_ptr <= AW'(rd_ptr + 1'b1);
      case ({do_push, do_pop})
        2'b10:   level <= LW'(level + 1'b1);
        2'b01:   level <= LW'(level - 1'b1);
        default: level <= level;
      endcase
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/cbrt_dispatch.sv
// Dispatcher: queues operands, drives the cube-root unit, returns tagged roots.
module cbrt_dispatch
  import cbrt_pkg::*;
#(
  parameter int unsigned DEPTH = DEPTH_DEF,
  parameter int unsigned TAG_W = TAG_W_DEF,
  parameter int unsigned DW    = DW_DEF,
  parameter int unsigned RW    = RW_DEF,
  parameter int unsigned TMO   = TMO_DEF
) (
  input logic             clk_i,
  input logic             rst_i,
  cbrt_dispatch_if.master bus
);
  localparam int unsigned   LW       = $clog2(DEPTH) + 1;
  localparam int unsigned   TW       = $clog2(TMO + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TMO - 1);

  state_t            state_q, state_d;
  logic [DW-1:0]     root_a_q, root_a_d;
  logic              start_q, start_d;
  logic [RW-1:0]     out_data_q, out_data_d;
  logic [TAG_W-1:0]  out_tag_q, out_tag_d;
  logic [TAG_W-1:0]  tag_q, tag_d;
  logic [TAG_W-1:0]  seq_q, seq_d;
  logic              out_valid_q, out_valid_d;
  logic [DONE_W-1:0] done_q, done_d;
  logic              err_q, err_d;
  logic [TW-1:0]     tmo_q, tmo_d;

  logic              fifo_push;
  logic              fifo_pop;
  logic              fifo_full_c;
  logic              fifo_empty_c;
  logic [DW-1:0]     fifo_head_c;
  logic [LW-1:0]     fifo_level;

  assign fifo_push = bus.in_valid_i && !fifo_full_c;

  cbrt_op_fifo #(
    .DEPTH (DEPTH),
    .DW    (DW)
  ) u_fifo (
    .clk     (clk_i),
    .rst_n   (rst_i),
    .push    (fifo_push),
    .pop     (fifo_pop),
    .wdata   (bus.in_data_i),
    .rdata_c (fifo_head_c),
    .level   (fifo_level),
    .full_c  (fifo_full_c),
    .empty_c (fifo_empty_c)
  );

  // State and output registers; reset discards any operation in flight.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q     <= S_IDLE;
      root_a_q    <= '0;
      start_q     <= 1'b0;
      out_data_q  <= '0;
      out_tag_q   <= '0;
      tag_q       <= '0;
      seq_q       <= '0;
      out_valid_q <= 1'b0;
      done_q      <= '0;
      err_q       <= 1'b0;
      tmo_q       <= '0;
    end else begin
      state_q     <= state_d;
      root_a_q    <= root_a_d;
      start_q     <= start_d;
      out_data_q  <= out_data_d;
      out_tag_q   <= out_tag_d;
      tag_q       <= tag_d;
      seq_q       <= seq_d;
      out_valid_q <= out_valid_d;
      done_q      <= done_d;
      err_q       <= err_d;
      tmo_q       <= tmo_d;
    end
  end

  // Next state: launch only with an empty result slot so results stay in order.
  always_comb begin
    state_d     = state_q;
    root_a_d    = root_a_q;
    start_d     = 1'b0;
    out_data_d  = out_data_q;
    out_tag_d   = out_tag_q;
    tag_d       = tag_q;
    seq_d       = seq_q;
    out_valid_d = out_valid_q && !bus.out_ready_i;
    done_d      = done_q;
    err_d       = err_q;
    tmo_d       = tmo_q;
    fifo_pop    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (!fifo_empty_c && !out_valid_q) begin
          fifo_pop = 1'b1;
          root_a_d = fifo_head_c;
          tag_d    = seq_q;
          seq_d    = TAG_W'(seq_q + 1'b1);
          start_d  = 1'b1;
          state_d  = S_START;
        end
      end
      S_START: begin
        tmo_d   = '0;
        state_d = S_WAIT_HI;
      end
      S_WAIT_HI: begin
        if (bus.root_busy_i) begin
          state_d = S_WAIT_LO;
        end else if (tmo_q == TMO_LAST) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          tmo_d = TW'(tmo_q + 1'b1);
        end
      end
      S_WAIT_LO: begin
        if (!bus.root_busy_i) begin
          out_data_d  = bus.root_y_i;
          out_tag_d   = tag_q;
          out_valid_d = 1'b1;
          if (done_q != '1) done_d = DONE_W'(done_q + 1'b1);
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.in_ready_o   = !fifo_full_c;
  assign bus.root_a_o     = root_a_q;
  assign bus.root_start_o = start_q;
  assign bus.out_data_o   = out_data_q;
  assign bus.out_tag_o    = out_tag_q;
  assign bus.out_valid_o  = out_valid_q;
  assign bus.level_o      = fifo_level;
  assign bus.done_cnt_o   = done_q;
  assign bus.err_o        = err_q;

endmodule

// File: tb/tb_cbrt_dispatch.sv
// Bench for cbrt_dispatch: queue-based model with per-cycle compare plus directed checks.
module tb_cbrt_dispatch;
  localparam int DEPTH = 4;
  localparam int TAG_W = 2;
  localparam int TMO   = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  cbrt_dispatch_if bus ();
  cbrt_dispatch dut (.clk_i(clk), .rst_i(rst_n), .bus(bus));

  int total = 0;
  int bad   = 0;

  // Bench controls
  bit chk_en   = 0;
  bit bfm_dead = 0;
  int busy_len = 3;
  int bfm_cnt  = 0;

  // Model state
  int mq[$];
  int m_inf = 0, m_k = 0, m_seen = 0, m_pend = 0;
  int m_root_a = 0, m_cur_tag = 0, m_seq = 0;
  int m_data = 0, m_tag = 0, m_done = 0, m_err = 0;
  int pre_level;
  bit exp_start, new_res;

  // Observations
  int res_data[$];
  int res_tag[$];
  int start_a[$];
  bit saw_full = 0, saw_nr = 0;

  function automatic int cbrt(input int a);
    int r = 0;
    while ((r + 1) * (r + 1) * (r + 1) <= a) r++;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_res(input int idx, input int d, input int t);
    if (idx < res_data.size()) begin
      chk($sformatf("res%0d_data", idx), res_data[idx], d);
      chk($sformatf("res%0d_tag", idx), res_tag[idx], t);
    end else begin
      total++;
      bad++;
      $display("FAIL res%0d_missing: got %0d results want at least %0d", idx, res_data.size(), idx + 1);
    end
  endtask

  // Cube-root unit BFM: busy rises in the start cycle, result valid as busy falls.
  initial begin
    bus.root_busy_i = 1'b0;
    bus.root_y_i    = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        bus.root_busy_i = 1'b0;
        bfm_cnt = 0;
      end else if (bus.root_start_o && !bfm_dead) begin
        bus.root_busy_i = 1'b1;
        bus.root_y_i    = 4'hF;
        bfm_cnt = busy_len;
      end else if (bfm_cnt > 0) begin
        bfm_cnt--;
        if (bfm_cnt == 0) begin
          bus.root_busy_i = 1'b0;
          bus.root_y_i    = 4'(cbrt(int'(bus.root_a_o)));
        end
      end
    end
  end

  // Per-cycle compare against the queue model, sampled 1 time unit after each edge.
  always @(posedge clk) begin
    #1;
    if (!rst_n) begin
      chk_en = 1;
      chk("rst_root_a", bus.root_a_o, 0);
      chk("rst_start", bus.root_start_o, 0);
      chk("rst_out_data", bus.out_data_o, 0);
      chk("rst_out_tag", bus.out_tag_o, 0);
      chk("rst_out_valid", bus.out_valid_o, 0);
      chk("rst_level", bus.level_o, 0);
      chk("rst_done", bus.done_cnt_o, 0);
      chk("rst_err", bus.err_o, 0);
      mq.delete();
      m_inf = 0; m_pend = 0; m_seq = 0; m_done = 0; m_err = 0;
      m_root_a = 0; m_data = 0; m_tag = 0;
    end else if (chk_en) begin
      pre_level = mq.size();
      new_res   = 0;
      exp_start = !m_inf && pre_level > 0 && !m_pend;
      chk("start", bus.root_start_o, exp_start);
      if (bus.root_start_o) start_a.push_back(int'(bus.root_a_o));
      if (exp_start) begin
        m_root_a  = mq.pop_front();
        m_cur_tag = m_seq;
        m_seq     = (m_seq + 1) % (1 << TAG_W);
        m_inf = 1; m_k = 0; m_seen = 0;
      end else if (m_inf) begin
        m_k++;
        if (m_k >= 2) begin
          if (!m_seen) begin
            if (bus.root_busy_i) m_seen = 1;
            else if (m_k == TMO + 1) begin
              m_err = 1;
              m_inf = 0;
            end
          end else if (!bus.root_busy_i) begin
            new_res = 1;
            m_inf   = 0;
          end
        end
      end
      if (new_res) begin
        m_data = cbrt(m_root_a);
        m_tag  = m_cur_tag;
        m_pend = 1;
        if (m_done < 65535) m_done++;
      end else if (m_pend && bus.out_ready_i) begin
        m_pend = 0;
      end
      if (bus.in_valid_i && pre_level != DEPTH) mq.push_back(int'(bus.in_data_i));

      chk("level", bus.level_o, mq.size());
      chk("in_ready", bus.in_ready_o, mq.size() != DEPTH);
      chk("root_a", bus.root_a_o, m_root_a);
      chk("out_valid", bus.out_valid_o, m_pend);
      if (m_pend) begin
        chk("out_data", bus.out_data_o, m_data);
        chk("out_tag", bus.out_tag_o, m_tag);
      end
      chk("done_cnt", bus.done_cnt_o, m_done);
      chk("err", bus.err_o, m_err);
      if (new_res) begin
        res_data.push_back(int'(bus.out_data_o));
        res_tag.push_back(int'(bus.out_tag_o));
      end
      if (bus.level_o == DEPTH) saw_full = 1;
      if (!bus.in_ready_o) saw_nr = 1;
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rel_in_ready", bus.in_ready_o, 1);
    chk("rel_level", bus.level_o, 0);
  endtask

  task automatic push(input int v);
    int n = 0;
    @(negedge clk);
    bus.in_data_i  = 8'(v);
    bus.in_valid_i = 1'b1;
    while (!bus.in_ready_o && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      total++;
      bad++;
      $display("FAIL push_timeout: operand %0d not accepted, wanted in_ready=1", v);
    end
    @(posedge clk);
  endtask

  task automatic idle();
    @(negedge clk);
    bus.in_valid_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, wanted finish");
    $fatal(1);
  end

  initial begin
    int base;
    bus.in_data_i   = '0;
    bus.in_valid_i  = 1'b0;
    bus.out_ready_i = 1'b1;

    // Single operand
    do_reset();
    base = res_data.size();
    start_a.delete();
    push(27);
    idle();
    repeat (15) @(negedge clk);
    chk("t1_starts", start_a.size(), 1);
    if (start_a.size() > 0) chk("t1_root_a", start_a[0], 27);
    chk_res(base, 3, 0);
    chk("t1_done", bus.done_cnt_o, 1);

    // Back-to-back burst filling the FIFO
    do_reset();
    base = res_data.size();
    saw_full = 0; saw_nr = 0;
    push(0); push(8); push(64); push(125); push(255);
    idle();
    repeat (60) @(negedge clk);
    chk("t2_full_seen", saw_full, 1);
    chk("t2_not_ready_seen", saw_nr, 1);
    chk_res(base + 0, 0, 0);
    chk_res(base + 1, 2, 1);
    chk_res(base + 2, 4, 2);
    chk_res(base + 3, 5, 3);
    chk_res(base + 4, 6, 0);
    chk("t2_done", bus.done_cnt_o, 5);

    // Output backpressure blocks the next launch
    do_reset();
    base = res_data.size();
    start_a.delete();
    bus.out_ready_i = 1'b0;
    push(27); push(64);
    idle();
    repeat (20) @(negedge clk);
    chk("t3_hold_valid", bus.out_valid_o, 1);
    chk("t3_hold_data", bus.out_data_o, 3);
    chk("t3_hold_level", bus.level_o, 1);
    chk("t3_hold_starts", start_a.size(), 1);
    bus.out_ready_i = 1'b1;
    repeat (20) @(negedge clk);
    chk("t3_rel_starts", start_a.size(), 2);
    chk_res(base + 0, 3, 0);
    chk_res(base + 1, 4, 1);

    // Root unit never goes busy: timeouts drop operations but consume tags
    do_reset();
    base = res_data.size();
    start_a.delete();
    bfm_dead = 1;
    push(8); push(27);
    idle();
    repeat (30) @(negedge clk);
    chk("t4_err", bus.err_o, 1);
    chk("t4_valid", bus.out_valid_o, 0);
    chk("t4_done", bus.done_cnt_o, 0);
    chk("t4_starts", start_a.size(), 2);
    if (start_a.size() > 1) chk("t4_second_a", start_a[1], 27);
    chk("t4_no_result", res_data.size(), base);
    bfm_dead = 0;
    push(64);
    idle();
    repeat (20) @(negedge clk);
    chk_res(base, 4, 2);
    chk("t4_err_sticky", bus.err_o, 1);

    // Reset while waiting on a slow result with three operands queued
    busy_len = 30;
    push(1); push(8); push(27); push(64);
    idle();
    repeat (2) @(negedge clk);
    chk("t5_pre_level", bus.level_o, 3);
    chk("t5_pre_err", bus.err_o, 1);
    chk("t5_pre_done", bus.done_cnt_o, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_async_start", bus.root_start_o, 0);
    chk("t5_async_root_a", bus.root_a_o, 0);
    chk("t5_async_valid", bus.out_valid_o, 0);
    chk("t5_async_data", bus.out_data_o, 0);
    chk("t5_async_level", bus.level_o, 0);
    chk("t5_async_done", bus.done_cnt_o, 0);
    chk("t5_async_err", bus.err_o, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    base = res_data.size();
    repeat (40) @(negedge clk);
    chk("t5_no_result", res_data.size(), base);
    chk("t5_level", bus.level_o, 0);
    chk("t5_valid", bus.out_valid_o, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
